mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_controller.sv | 179 +++++++++++++++++
 tb/tb_mc_controller.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// Multicycle MIPS-subset control unit: a Moore FSM that sequences fetch, decode,
// execute, memory and writeback, plus a combinational PC-load enable for branches.
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_en,
  output logic       i_or_d,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] pc_src,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [2:0] ALU_NOR = 3'b011;

  // Unknown function codes fall back to add so the datapath stays benign.
  function automatic logic [2:0] funct_to_alu(input logic [5:0] f);
    case (f)
      6'b100000: funct_to_alu = ALU_ADD;
      6'b100010: funct_to_alu = ALU_SUB;
      6'b100100: funct_to_alu = ALU_AND;
      6'b100101: funct_to_alu = ALU_OR;
      6'b101010: funct_to_alu = ALU_SLT;
      6'b100111: funct_to_alu = ALU_NOR;
      default:   funct_to_alu = ALU_ADD;
    endcase
  endfunction

  state_t state_q, state_d;

  logic pc_write_raw;
  logic ir_write_raw;
  logic reg_write_raw;
  logic mem_write_raw;
  logic branch_take;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = S_FETCH;
    pc_write_raw  = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    mem_write_raw = 1'b0;
    i_or_d        = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_control   = ALU_ADD;
    pc_src        = 2'b00;
    illegal_op    = 1'b0;

    case (state_q)
      S_FETCH: begin
        ir_write_raw = 1'b1;
        pc_write_raw = 1'b1;
        alu_src_b    = 2'b01;
        state_d      = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (op)
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_RTYPE:       state_d = S_RTYPEEX;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_ADDI:        state_d = S_ADDIEX;
          OP_J:           state_d = S_JUMP;
          default: begin
            state_d    = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (op == OP_LW)      state_d = S_MEMRD;
        else if (op == OP_SW) state_d = S_MEMWR;
        else                  state_d = S_FETCH;
      end
      S_MEMRD: begin
        i_or_d  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg    = 1'b1;
        reg_write_raw = 1'b1;
      end
      S_MEMWR: begin
        i_or_d        = 1'b1;
        mem_write_raw = 1'b1;
      end
      S_RTYPEEX: begin
        alu_src_a   = 1'b1;
        alu_control = funct_to_alu(funct);
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst       = 1'b1;
        reg_write_raw = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_src      = 2'b01;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write_raw = 1'b1;
      end
      S_JUMP: begin
        pc_src       = 2'b10;
        pc_write_raw = 1'b1;
      end
      // Encodings 12-15 are unreachable; park every output at zero and recover.
      default: begin
        alu_control = 3'b000;
        state_d     = S_FETCH;
      end
    endcase
  end

  // The branch decision uses the live zero flag, so pc_en is not purely Moore.
  assign branch_take = (state_q == S_BRANCH) &&
                       (((op == OP_BEQ) && zero) || ((op == OP_BNE) && !zero));

  assign pc_en     = !reset && (pc_write_raw || branch_take);
  assign ir_write  = !reset && ir_write_raw;
  assign reg_write = !reset && reg_write_raw;
  assign mem_write = !reset && mem_write_raw;
  assign state     = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: per-cycle expected control words are queued
// for each instruction and compared against the DUT on the falling edge.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pc_en, i_or_d, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, illegal_op;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_control;
  logic [3:0] state;

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pc_en(pc_en), .i_or_d(i_or_d), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .pc_src(pc_src), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_en;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;
    logic       i_or_d;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [1:0] pc_src;
    logic       illegal_op;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  function automatic exp_t mk(input logic [3:0] st, input logic pce, irw, rw, mw,
                              iod, m2r, rd, sa, input logic [1:0] sb,
                              input logic [2:0] ac, input logic [1:0] ps,
                              input logic il);
    mk = {st, pce, irw, rw, mw, iod, m2r, rd, sa, sb, ac, ps, il};
  endfunction

  function automatic exp_t e_fetch();         return mk(0, 1,1,0,0,0,0,0,0, 2'b01, 3'b010, 2'b00, 0); endfunction
  function automatic exp_t e_fetch_rst();     return mk(0, 0,0,0,0,0,0,0,0, 2'b01, 3'b010, 2'b00, 0); endfunction
  function automatic exp_t e_decode(logic il); return mk(1, 0,0,0,0,0,0,0,0, 2'b11, 3'b010, 2'b00, il); endfunction
  function automatic exp_t e_memadr();        return mk(2, 0,0,0,0,0,0,0,1, 2'b10, 3'b010, 2'b00, 0); endfunction
  function automatic exp_t e_memrd();         return mk(3, 0,0,0,0,1,0,0,0, 2'b00, 3'b010, 2'b00, 0); endfunction
  function automatic exp_t e_memwb();         return mk(4, 0,0,1,0,0,1,0,0, 2'b00, 3'b010, 2'b00, 0); endfunction
  function automatic exp_t e_memwr();         return mk(5, 0,0,0,1,1,0,0,0, 2'b00, 3'b010, 2'b00, 0); endfunction
  function automatic exp_t e_rtype(logic [2:0] ac); return mk(6, 0,0,0,0,0,0,0,1, 2'b00, ac, 2'b00, 0); endfunction
  function automatic exp_t e_aluwb();         return mk(7, 0,0,1,0,0,0,1,0, 2'b00, 3'b010, 2'b00, 0); endfunction
  function automatic exp_t e_branch(logic p); return mk(8, p,0,0,0,0,0,0,1, 2'b00, 3'b110, 2'b01, 0); endfunction
  function automatic exp_t e_addiex();        return mk(9, 0,0,0,0,0,0,0,1, 2'b10, 3'b010, 2'b00, 0); endfunction
  function automatic exp_t e_addiwb();        return mk(10,0,0,1,0,0,0,0,0, 2'b00, 3'b010, 2'b00, 0); endfunction
  function automatic exp_t e_jump();          return mk(11,1,0,0,0,0,0,0,0, 2'b00, 3'b010, 2'b10, 0); endfunction

  task automatic push(input exp_t e, input string tag);
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Called on a falling edge; consumes one expectation per clock cycle.
  task automatic run_queue();
    exp_t  obs, exp_v;
    string tag;
    while (sb_q.size() > 0) begin
      #1;
      obs = {state, pc_en, ir_write, reg_write, mem_write, i_or_d, mem_to_reg,
             reg_dst, alu_src_a, alu_src_b, alu_control, pc_src, illegal_op};
      exp_v = sb_q.pop_front();
      tag   = tag_q.pop_front();
      checks++;
      assert (obs === exp_v) else begin
        errors++;
        $error("FAIL %s: observed %05h expected %05h (state obs %0d exp %0d)",
               tag, obs, exp_v, obs.st, exp_v.st);
      end
      @(negedge clk);
    end
  endtask

  task automatic rtype_case(input logic [5:0] f, input logic [2:0] ac, input string tag);
    op = 6'b000000; funct = f;
    push(e_fetch(), {tag, "_fetch"});
    push(e_decode(1'b0), {tag, "_decode"});
    push(e_rtype(ac), {tag, "_rtypeex"});
    push(e_aluwb(), {tag, "_aluwb"});
    run_queue();
  endtask

  task automatic branch_case(input logic [5:0] o, input logic z, input logic take, input string tag);
    op = o; zero = z;
    push(e_fetch(), {tag, "_fetch"});
    push(e_decode(1'b0), {tag, "_decode"});
    push(e_branch(take), {tag, "_branch"});
    run_queue();
  endtask

  initial begin
    reset = 1'b1; op = 6'b000000; funct = 6'b100000; zero = 1'b0;
    repeat (2) @(negedge clk);
    push(e_fetch_rst(), "reset_hold");
    run_queue();
    reset = 1'b0;

    op = 6'b100011;
    push(e_fetch(), "lw_fetch");   push(e_decode(1'b0), "lw_decode");
    push(e_memadr(), "lw_memadr"); push(e_memrd(), "lw_memrd");
    push(e_memwb(), "lw_memwb");
    run_queue();

    op = 6'b101011;
    push(e_fetch(), "sw_fetch");   push(e_decode(1'b0), "sw_decode");
    push(e_memadr(), "sw_memadr"); push(e_memwr(), "sw_memwr");
    run_queue();

    rtype_case(6'b100000, 3'b010, "r_add");
    rtype_case(6'b100010, 3'b110, "r_sub");
    rtype_case(6'b100100, 3'b000, "r_and");
    rtype_case(6'b100101, 3'b001, "r_or");
    rtype_case(6'b101010, 3'b111, "r_slt");
    rtype_case(6'b100111, 3'b011, "r_nor");
    rtype_case(6'b000000, 3'b010, "r_unknown");

    branch_case(6'b000100, 1'b1, 1'b1, "beq_z1");
    branch_case(6'b000100, 1'b0, 1'b0, "beq_z0");
    branch_case(6'b000101, 1'b0, 1'b1, "bne_z0");
    branch_case(6'b000101, 1'b1, 1'b0, "bne_z1");
    zero = 1'b0;

    op = 6'b001000;
    push(e_fetch(), "addi_fetch");   push(e_decode(1'b0), "addi_decode");
    push(e_addiex(), "addi_ex");     push(e_addiwb(), "addi_wb");
    run_queue();

    op = 6'b000010;
    push(e_fetch(), "j_fetch"); push(e_decode(1'b0), "j_decode"); push(e_jump(), "j_jump");
    run_queue();

    op = 6'b111111;
    push(e_fetch(), "ill_fetch"); push(e_decode(1'b1), "ill_decode");
    run_queue();

    // lw interrupted by reset while in MEMRD
    op = 6'b100011;
    push(e_fetch(), "lwrst_fetch"); push(e_decode(1'b0), "lwrst_decode");
    push(e_memadr(), "lwrst_memadr");
    run_queue();
    reset = 1'b1;
    push(e_memrd(), "lwrst_memrd_rst");
    push(e_fetch_rst(), "lwrst_after_edge");
    run_queue();
    reset = 1'b0;

    op = 6'b001000;
    push(e_fetch(), "recov_fetch");  push(e_decode(1'b0), "recov_decode");
    push(e_addiex(), "recov_ex");    push(e_addiwb(), "recov_wb");
    push(e_fetch(), "recov_refetch");
    run_queue();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
